// File: rtl/rr_arb_pkg.sv
// Shared types, default sizes and the round-robin search helper for the
// 8-way arbiter.
package rr_arb_pkg;

    localparam int RR_N_REQ   = 8;
    localparam int RR_IDX_W   = 3;
    localparam int RR_TMO_CYC = 16;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    // First set request at or after ptr, searching upward with wrap.
    // Walking offsets from high to low lets the smallest offset win.
    function automatic logic [RR_IDX_W-1:0] rr_pick(
        input logic [RR_N_REQ-1:0] req,
        input logic [RR_IDX_W-1:0] ptr
    );
        logic [RR_IDX_W-1:0] idx;
        logic [RR_IDX_W-1:0] pick;
        pick = ptr;
        for (int i = RR_N_REQ - 1; i >= 0; i--) begin
            idx = ptr + RR_IDX_W'(i);
            if (req[idx]) begin
                pick = idx;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/onehot_dec.sv
// Binary-to-one-hot decoder with enable; output is all-zero when en is low.
module onehot_dec
    import rr_arb_pkg::*;
#(
    parameter int IDX_W = RR_IDX_W,
    parameter int N_OUT = RR_N_REQ
) (
    input  logic [IDX_W-1:0] idx,
    input  logic             en,
    output logic [N_OUT-1:0] onehot
);

    genvar gi;
    generate
        for (gi = 0; gi < N_OUT; gi++) begin : g_bit
            assign onehot[gi] = en && (idx == IDX_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with hold-until-release ownership.
// Optional forced release on a hold limit when RR_ARB_TIMEOUT_EN is defined.
module rr_arbiter8
    import rr_arb_pkg::*;
#(
    parameter int N_REQ   = RR_N_REQ,
    parameter int IDX_W   = RR_IDX_W,
    parameter int TMO_CYC = RR_TMO_CYC
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid
`ifdef RR_ARB_TIMEOUT_EN
    ,
    output logic             timeout
`endif
);

    generate
        if ((2 ** IDX_W) != N_REQ || TMO_CYC < 1) begin : g_cfg_err
            $error("rr_arbiter8: need 2**IDX_W == N_REQ and TMO_CYC >= 1");
        end
    endgenerate

    arb_state_t       state_reg;
    logic [IDX_W-1:0] ptr_reg;
    logic [IDX_W-1:0] grant_idx_reg;
    logic             grant_valid_reg;

    logic [IDX_W-1:0] pick_next;
    logic             owner_release;
    logic             tmo_hit;
    logic             release_now;

    assign pick_next     = rr_pick(req, ptr_reg);
    assign owner_release = done | ~req[grant_idx_reg];
    assign release_now   = owner_release | tmo_hit;

`ifdef RR_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TMO_CYC + 1);

    logic [CNT_W-1:0] cnt_reg;
    logic             timeout_reg;

    // cnt_reg counts completed BUSY cycles of the current grant, so the
    // limit is hit during the TMO_CYC-th BUSY cycle.
    assign tmo_hit = (state_reg == BUSY) && (cnt_reg == CNT_W'(TMO_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg     <= '0;
            timeout_reg <= 1'b0;
        end else begin
            timeout_reg <= tmo_hit && !owner_release;
            if (state_reg == BUSY && !release_now) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end else begin
                cnt_reg <= '0;
            end
        end
    end

    assign timeout = timeout_reg;
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            ptr_reg         <= '0;
            grant_idx_reg   <= '0;
            grant_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (|req) begin
                        state_reg       <= BUSY;
                        grant_idx_reg   <= pick_next;
                        grant_valid_reg <= 1'b1;
                    end
                end
                BUSY: begin
                    // Going through IDLE on every release gives the
                    // mandatory one-cycle gap before the next grant.
                    if (release_now) begin
                        state_reg       <= IDLE;
                        ptr_reg         <= grant_idx_reg + IDX_W'(1);
                        grant_idx_reg   <= '0;
                        grant_valid_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg       <= IDLE;
                    grant_idx_reg   <= '0;
                    grant_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    onehot_dec #(
        .IDX_W (IDX_W),
        .N_OUT (N_REQ)
    ) u_grant_dec (
        .idx    (grant_idx_reg),
        .en     (grant_valid_reg),
        .onehot (grant)
    );

    assign grant_idx   = grant_idx_reg;
    assign grant_valid = grant_valid_reg;

endmodule

// File: doc/rr_arbiter8.md
RR_ARBITER8 -- requirements
Module: rr_arbiter8

Interface
REQ-001 Parameter N_REQ, default 8: number of requesters; fixed at 8 for this revision.
REQ-002 Parameter IDX_W, default 3: width of the grant index; must satisfy 2**IDX_W == N_REQ.
REQ-003 Parameter TMO_CYC, default 16: grant-hold cycle limit, used only with the Configuration feature.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 req  input  8  request vector; bit i means requester i wants the shared resource.
REQ-007 done  input  1  single-cycle pulse from the current owner releasing the resource.
REQ-008 grant  output  8  one-hot grant; all-zero when no owner.
REQ-009 grant_idx  output  3  binary index of the owner; 0 when grant_valid is 0.
REQ-010 grant_valid  output  1  high while an owner holds the resource.
REQ-011 timeout  output  1  single-cycle pulse on forced release; present only with RR_ARB_TIMEOUT_EN.

Function
REQ-012 FSM states SHALL be IDLE and BUSY, with no others.
REQ-013 In IDLE with req != 0, the FSM SHALL select the first set bit at or after ptr, searching upward with wrap from 7 to 0, and enter BUSY on the next edge, giving 1-cycle grant latency.
REQ-014 In IDLE with req == 0, the FSM SHALL stay in IDLE with grant = 0.
REQ-015 grant SHALL equal exactly 1 << grant_idx while in BUSY, and 0 in IDLE; never more than one bit set.
REQ-016 In BUSY, the grant SHALL hold until done = 1 or req[grant_idx] = 0; either event returns the FSM to IDLE on the next edge.
REQ-017 On release, ptr SHALL become (grant_idx + 1) mod 8; ptr wraps from 7 to 0.
REQ-018 After release, IDLE SHALL last exactly one cycle before any new grant, including a re-grant to the same requester.
REQ-019 done asserted in IDLE SHALL be ignored.
REQ-020 Simultaneous done and req changes SHALL be handled as follows: done takes effect, and the new req is sampled in the following IDLE cycle.
REQ-021 When only the previous owner requests after release, it SHALL be re-granted.
REQ-022 Outputs SHALL be registered, with no combinational path from req or done to grant.

Reset
REQ-023 Asserting rst_n = 0 at any time, including mid-grant, SHALL immediately force state = IDLE, ptr = 0, grant = 0, grant_idx = 0, grant_valid = 0, timeout = 0.
REQ-024 The first grant after reset deassertion SHALL favour requester 0.

Configuration
REQ-025 With macro RR_ARB_TIMEOUT_EN defined, a cycle counter SHALL run in BUSY; on reaching TMO_CYC cycles with no release, the FSM SHALL force release (ptr advances per REQ-017) and pulse timeout for 1 cycle.
REQ-026 Without RR_ARB_TIMEOUT_EN, the counter and the timeout port SHALL be absent, and grants SHALL hold indefinitely.

Structure
REQ-027 Package rr_arb_pkg SHALL hold the state enum (IDLE, BUSY), N_REQ, IDX_W and the TMO_CYC default.
REQ-028 Sub-module onehot_dec (3-bit in, 8-bit one-hot out) SHALL generate grant from the registered grant_idx.

Verification
REQ-029 Reset, then req = 8'b0000_0001 -> grant = 8'h01 and grant_idx = 0 one cycle later; done pulse -> grant = 0 on the next cycle.
REQ-030 req = 8'hFF held, done every 3rd cycle -> grant_idx sequence 0,1,2,...,7,0 with no skips or repeats.
REQ-031 Owner 7, req = 8'h81, done -> next grant to 0 (wrap), then to 7.
REQ-032 req = 8'h04 with owner 2 dropping req and no done -> release; re-grant to 2 after one IDLE cycle.
REQ-033 rst_n pulsed low while owner 5 -> grant = 0 asynchronously; after reset, req = 8'h21 -> grant to 0.
REQ-034 With RR_ARB_TIMEOUT_EN, req = 8'h08 held and no done -> timeout pulse after 16 BUSY cycles; grant to 3 again after one IDLE cycle.
